exc_word_gen: RTL and testbench

Per-lane exception collector and redirect sequencer for the dual-issue pipeline.

- Gathers exception causes raised in ID, EX and MEM for lanes 1 and 2.
- Carries them with each instruction to MEM, where it encodes them into the 16-bit `cp0_int_contr_word_1/2` consumed by CP0.
- Reacts to CP0's `cp0_cln_*`/`cp0_intexp_*` responses by flushing the pipeline and redirecting fetch to the exception vector or to `EPC_o`.

---
 rtl/exc_word_gen_pkg.sv | 57 +++++
 rtl/exc_lane_pipe.sv | 78 +++++++
 rtl/exc_word_gen.sv | 150 +++++++++++++++
 tb/tb_exc_word_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_word_gen_pkg.sv
// Shared definitions for the exception word generator: flag layout, word fields,
// sequencer states and the fixed-priority cause encoder.
package exc_word_gen_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam int FLAG_IF_ADEL = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_OV      = 2;
    localparam int FLAG_BREAK   = 3;
    localparam int FLAG_SYSCALL = 4;
    localparam int FLAG_ADEL    = 5;
    localparam int FLAG_ERET    = 6;
    localparam int FLAG_ADES    = 7;

    localparam int WORD_VALID_BIT = 15;
    localparam int WORD_DELAY_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE
    } fsm_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        delay;
        logic [7:0]  flags;
        logic [31:0] badaddr;
    } stage_t;

    // Oldest-detected cause wins: fetch, decode, then EX, then MEM, eret last.
    function automatic logic [7:0] prio_onehot(input logic [7:0] flags);
        logic [7:0] oh;
        oh = '0;
        if (flags[FLAG_IF_ADEL])      oh[FLAG_IF_ADEL] = 1'b1;
        else if (flags[FLAG_RI])      oh[FLAG_RI]      = 1'b1;
        else if (flags[FLAG_BREAK])   oh[FLAG_BREAK]   = 1'b1;
        else if (flags[FLAG_SYSCALL]) oh[FLAG_SYSCALL] = 1'b1;
        else if (flags[FLAG_OV])      oh[FLAG_OV]      = 1'b1;
        else if (flags[FLAG_ADEL])    oh[FLAG_ADEL]    = 1'b1;
        else if (flags[FLAG_ADES])    oh[FLAG_ADES]    = 1'b1;
        else if (flags[FLAG_ERET])    oh[FLAG_ERET]    = 1'b1;
        return oh;
    endfunction

    function automatic logic [15:0] make_word(input logic [7:0] onehot, input logic delay);
        logic [15:0] w;
        w                 = '0;
        w[7:0]            = onehot;
        w[WORD_DELAY_BIT] = delay;
        w[WORD_VALID_BIT] = |onehot;
        return w;
    endfunction

endpackage

// File: rtl/exc_lane_pipe.sv
// One lane's EX/MEM exception carrier plus the MEM-stage control word encoder.
module exc_lane_pipe
    import exc_word_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_in_delay_i,
    input  logic        id_if_adel_i,
    input  logic        id_ri_i,
    input  logic        id_break_i,
    input  logic        id_syscall_i,
    input  logic        id_eret_i,
    input  logic        ex_ov_i,
    input  logic        mem_adel_i,
    input  logic        mem_ades_i,
    input  logic [31:0] mem_vaddr_i,
    output logic [15:0] word_o,
    output logic [31:0] pc_o,
    output logic [31:0] badaddr_o
);

    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;

    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        ex_d  = ex_q;
        mem_d = mem_q;
        if (flush_i) begin
            ex_d.valid  = 1'b0;
            mem_d.valid = 1'b0;
        end else if (!stall) begin
            ex_d.valid                = id_valid_i;
            ex_d.pc                   = id_pc_i;
            ex_d.delay                = id_in_delay_i;
            ex_d.flags                = '0;
            ex_d.flags[FLAG_IF_ADEL]  = id_if_adel_i;
            ex_d.flags[FLAG_RI]       = id_ri_i;
            ex_d.flags[FLAG_BREAK]    = id_break_i;
            ex_d.flags[FLAG_SYSCALL]  = id_syscall_i;
            ex_d.flags[FLAG_ERET]     = id_eret_i;
            ex_d.badaddr              = id_if_adel_i ? id_pc_i : 32'h0;

            mem_d                     = ex_q;
            mem_d.flags[FLAG_OV]      = ex_q.flags[FLAG_OV] | (ex_ov_i & ex_q.valid);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    logic [7:0] mem_flags;
    logic       mem_err;

    always_comb begin
        mem_flags            = mem_q.flags;
        mem_flags[FLAG_ADEL] = mem_adel_i;
        mem_flags[FLAG_ADES] = mem_ades_i;
        mem_err              = mem_q.valid & (mem_adel_i | mem_ades_i);
    end

    assign word_o    = mem_q.valid ? make_word(prio_onehot(mem_flags), mem_q.delay) : 16'h0;
    assign pc_o      = mem_q.pc;
    assign badaddr_o = mem_err ? mem_vaddr_i : mem_q.badaddr;

endmodule

// File: rtl/exc_word_gen.sv
// Dual-lane exception collector: builds CP0 control words and sequences the
// flush/redirect that follows a CP0 clean request.
module exc_word_gen
    import exc_word_gen_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
    parameter int          SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        id_valid_1,
    input  logic [31:0] id_pc_1,
    input  logic        id_in_delay_1,
    input  logic        id_if_adel_1,
    input  logic        id_ri_1,
    input  logic        id_break_1,
    input  logic        id_syscall_1,
    input  logic        id_eret_1,
    input  logic        ex_ov_1,
    input  logic        mem_adel_1,
    input  logic        mem_ades_1,
    input  logic [31:0] mem_vaddr_1,
    input  logic        id_valid_2,
    input  logic [31:0] id_pc_2,
    input  logic        id_in_delay_2,
    input  logic        id_if_adel_2,
    input  logic        id_ri_2,
    input  logic        id_break_2,
    input  logic        id_syscall_2,
    input  logic        id_eret_2,
    input  logic        ex_ov_2,
    input  logic        mem_adel_2,
    input  logic        mem_ades_2,
    input  logic [31:0] mem_vaddr_2,
    input  logic        cp0_cln_1,
    input  logic        cp0_cln_2,
    input  logic        cp0_intexp_1,
    input  logic        cp0_intexp_2,
    input  logic [31:0] EPC_o,
    output logic [15:0] cp0_int_contr_word_1,
    output logic [15:0] cp0_int_contr_word_2,
    output logic [31:0] PC_1,
    output logic [31:0] PC_2,
    output logic [31:0] orginalVritualAddrT_1,
    output logic [31:0] orginalVritualAddrT_2,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYCLES);

    fsm_state_e  state_q;
    logic [1:0]  settle_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic [15:0] word_1_raw;
    logic [15:0] word_2_raw;

    exc_lane_pipe u_lane_1 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush_i       (flush_q),
        .id_valid_i    (id_valid_1),
        .id_pc_i       (id_pc_1),
        .id_in_delay_i (id_in_delay_1),
        .id_if_adel_i  (id_if_adel_1),
        .id_ri_i       (id_ri_1),
        .id_break_i    (id_break_1),
        .id_syscall_i  (id_syscall_1),
        .id_eret_i     (id_eret_1),
        .ex_ov_i       (ex_ov_1),
        .mem_adel_i    (mem_adel_1),
        .mem_ades_i    (mem_ades_1),
        .mem_vaddr_i   (mem_vaddr_1),
        .word_o        (word_1_raw),
        .pc_o          (PC_1),
        .badaddr_o     (orginalVritualAddrT_1)
    );

    exc_lane_pipe u_lane_2 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush_i       (flush_q),
        .id_valid_i    (id_valid_2),
        .id_pc_i       (id_pc_2),
        .id_in_delay_i (id_in_delay_2),
        .id_if_adel_i  (id_if_adel_2),
        .id_ri_i       (id_ri_2),
        .id_break_i    (id_break_2),
        .id_syscall_i  (id_syscall_2),
        .id_eret_i     (id_eret_2),
        .ex_ov_i       (ex_ov_2),
        .mem_adel_i    (mem_adel_2),
        .mem_ades_i    (mem_ades_2),
        .mem_vaddr_i   (mem_vaddr_2),
        .word_o        (word_2_raw),
        .pc_o          (PC_2),
        .badaddr_o     (orginalVritualAddrT_2)
    );

    // Words stay silent until CP0's EXL/EPC catch up, otherwise CP0 would re-trigger.
    logic words_blocked;
    assign words_blocked = (state_q != ST_IDLE);

    assign cp0_int_contr_word_1 = words_blocked ? 16'h0 : word_1_raw;
    assign cp0_int_contr_word_2 = (words_blocked | word_1_raw[WORD_VALID_BIT]) ? 16'h0 : word_2_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            settle_q         <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cp0_cln_1 | cp0_cln_2) begin
                        redirect_pc_q    <= (cp0_intexp_1 | cp0_intexp_2) ? EXC_VECTOR : EPC_o;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        state_q          <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    settle_q <= SETTLE_INIT;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_q <= settle_q - 2'd1;
                    if (settle_q <= 2'd1) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_word_gen.sv
// Directed bench for exc_word_gen with hand-computed control words and redirect targets.
module tb_exc_word_gen;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        id_valid_1, id_in_delay_1, id_if_adel_1, id_ri_1, id_break_1, id_syscall_1, id_eret_1;
    logic        id_valid_2, id_in_delay_2, id_if_adel_2, id_ri_2, id_break_2, id_syscall_2, id_eret_2;
    logic [31:0] id_pc_1, id_pc_2, mem_vaddr_1, mem_vaddr_2, EPC_o;
    logic        ex_ov_1, ex_ov_2, mem_adel_1, mem_adel_2, mem_ades_1, mem_ades_2;
    logic        cp0_cln_1, cp0_cln_2, cp0_intexp_1, cp0_intexp_2;
    logic [15:0] word_1, word_2;
    logic [31:0] pc_1, pc_2, bad_1, bad_2, redirect_pc;
    logic        flush, redirect_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_word_gen dut (
        .clk(clk), .reset(reset), .stall(stall),
        .id_valid_1(id_valid_1), .id_pc_1(id_pc_1), .id_in_delay_1(id_in_delay_1),
        .id_if_adel_1(id_if_adel_1), .id_ri_1(id_ri_1), .id_break_1(id_break_1),
        .id_syscall_1(id_syscall_1), .id_eret_1(id_eret_1), .ex_ov_1(ex_ov_1),
        .mem_adel_1(mem_adel_1), .mem_ades_1(mem_ades_1), .mem_vaddr_1(mem_vaddr_1),
        .id_valid_2(id_valid_2), .id_pc_2(id_pc_2), .id_in_delay_2(id_in_delay_2),
        .id_if_adel_2(id_if_adel_2), .id_ri_2(id_ri_2), .id_break_2(id_break_2),
        .id_syscall_2(id_syscall_2), .id_eret_2(id_eret_2), .ex_ov_2(ex_ov_2),
        .mem_adel_2(mem_adel_2), .mem_ades_2(mem_ades_2), .mem_vaddr_2(mem_vaddr_2),
        .cp0_cln_1(cp0_cln_1), .cp0_cln_2(cp0_cln_2),
        .cp0_intexp_1(cp0_intexp_1), .cp0_intexp_2(cp0_intexp_2), .EPC_o(EPC_o),
        .cp0_int_contr_word_1(word_1), .cp0_int_contr_word_2(word_2),
        .PC_1(pc_1), .PC_2(pc_2),
        .orginalVritualAddrT_1(bad_1), .orginalVritualAddrT_2(bad_2),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_id();
        {id_valid_1, id_in_delay_1, id_if_adel_1, id_ri_1, id_break_1, id_syscall_1, id_eret_1} = '0;
        {id_valid_2, id_in_delay_2, id_if_adel_2, id_ri_2, id_break_2, id_syscall_2, id_eret_2} = '0;
        id_pc_1 = '0;
        id_pc_2 = '0;
    endtask

    task automatic clear_all();
        clear_id();
        {ex_ov_1, ex_ov_2, mem_adel_1, mem_adel_2, mem_ades_1, mem_ades_2} = '0;
        {cp0_cln_1, cp0_cln_2, cp0_intexp_1, cp0_intexp_2} = '0;
        mem_vaddr_1 = '0;
        mem_vaddr_2 = '0;
        EPC_o       = '0;
        stall       = 1'b0;
    endtask

    initial begin
        clear_all();
        reset = 1'b1;
        tick();
        tick();
        check("rst_word_1", 32'(word_1), 32'h0);
        check("rst_word_2", 32'(word_2), 32'h0);
        check("rst_pc_1", pc_1, 32'h0);
        check("rst_bad_2", bad_2, 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        reset = 1'b0;
        tick();

        // Syscall on lane 1: reaches MEM after the second edge.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0100; id_syscall_1 = 1'b1;
        tick();
        clear_id();
        check("syscall_not_early", 32'(word_1), 32'h0);
        tick();
        check("syscall_word_1", 32'(word_1), 32'h8010);
        check("syscall_pc_1", pc_1, 32'h8000_0100);
        check("syscall_word_2", 32'(word_2), 32'h0);
        tick();
        check("syscall_leaves", 32'(word_1), 32'h0);

        // RI beats EX overflow on the same instruction.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0104; id_ri_1 = 1'b1;
        tick();
        clear_id();
        ex_ov_1 = 1'b1;
        tick();
        ex_ov_1 = 1'b0;
        check("ri_over_ov", 32'(word_1), 32'h8002);
        tick();

        // Overflow alone on lane 2, then still beats a MEM load error.
        id_valid_2 = 1'b1; id_pc_2 = 32'h8000_0180;
        tick();
        clear_id();
        ex_ov_2 = 1'b1;
        tick();
        ex_ov_2 = 1'b0;
        check("ov_word_2", 32'(word_2), 32'h8004);
        mem_adel_2 = 1'b1; mem_vaddr_2 = 32'h0000_0ABD;
        #1;
        check("ov_over_adel", 32'(word_2), 32'h8004);
        check("adel_badaddr_2", bad_2, 32'h0000_0ABD);
        mem_adel_2 = 1'b0;
        tick();

        // Fetch address error: badaddr is the PC until a MEM error overrides it.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0121; id_if_adel_1 = 1'b1;
        tick();
        clear_id();
        tick();
        check("if_adel_word", 32'(word_1), 32'h8001);
        check("if_adel_badaddr", bad_1, 32'h8000_0121);
        mem_adel_1 = 1'b1; mem_vaddr_1 = 32'hDEAD_BEE1;
        #1;
        check("if_adel_over_adel", 32'(word_1), 32'h8001);
        check("mem_vaddr_override", bad_1, 32'hDEAD_BEE1);
        mem_adel_1 = 1'b0;
        tick();

        // Store error in a delay slot on lane 2.
        id_valid_2 = 1'b1; id_pc_2 = 32'h8000_0108; id_in_delay_2 = 1'b1;
        tick();
        clear_id();
        tick();
        check("delay_only_word_2", 32'(word_2), 32'h0200);
        mem_ades_2 = 1'b1; mem_vaddr_2 = 32'h1234_5671;
        #1;
        check("ades_word_2", 32'(word_2), 32'h8280);
        check("ades_badaddr_2", bad_2, 32'h1234_5671);
        mem_ades_2 = 1'b0;
        tick();

        // Lane 1 break suppresses lane 2's store error.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0110; id_break_1 = 1'b1;
        id_valid_2 = 1'b1; id_pc_2 = 32'h8000_0114; id_in_delay_2 = 1'b1;
        tick();
        clear_id();
        tick();
        mem_ades_2 = 1'b1; mem_vaddr_2 = 32'h1234_5671;
        #1;
        check("pair_word_1", 32'(word_1), 32'h8008);
        check("pair_word_2", 32'(word_2), 32'h0);
        check("pair_pc_2", pc_2, 32'h8000_0114);
        mem_ades_2 = 1'b0;
        tick();

        // Stall in IDLE holds the stages; the MEM word is re-presented.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0130; id_break_1 = 1'b1;
        tick();
        clear_id();
        stall = 1'b1;
        tick();
        check("stall_holds_ex", 32'(word_1), 32'h0);
        stall = 1'b0;
        tick();
        check("stall_release", 32'(word_1), 32'h8008);
        stall = 1'b1;
        tick();
        check("stall_represent", 32'(word_1), 32'h8008);
        stall = 1'b0;
        tick();

        // Interrupt/exception response with stall held across the flush.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0140; id_syscall_1 = 1'b1;
        tick();
        clear_id();
        tick();
        check("pre_cln_word_1", 32'(word_1), 32'h8010);
        cp0_cln_1 = 1'b1; cp0_intexp_1 = 1'b1; stall = 1'b1;
        tick();
        check("exc_flush", 32'(flush), 32'h1);
        check("exc_redirect_valid", 32'(redirect_valid), 32'h1);
        check("exc_redirect_pc", redirect_pc, 32'hBFC0_0380);
        check("exc_word_blocked", 32'(word_1), 32'h0);
        check("exc_stall_pc", pc_1, 32'h8000_0140);
        tick();
        check("settle_flush_low", 32'(flush), 32'h0);
        check("settle_redirect_low", 32'(redirect_valid), 32'h0);
        check("settle_word_blocked", 32'(word_1), 32'h0);
        tick();
        check("cln_ignored_outside_idle", 32'(flush), 32'h0);
        check("valid_cleared_under_stall", 32'(word_1), 32'h0);
        cp0_cln_1 = 1'b0; cp0_intexp_1 = 1'b0; stall = 1'b0;
        tick();

        // Eret on lane 2 redirects to EPC.
        id_valid_2 = 1'b1; id_pc_2 = 32'h8000_01F0; id_eret_2 = 1'b1;
        tick();
        clear_id();
        tick();
        check("eret_word_2", 32'(word_2), 32'h8040);
        cp0_cln_2 = 1'b1; EPC_o = 32'h8000_0200;
        tick();
        cp0_cln_2 = 1'b0;
        check("eret_flush", 32'(flush), 32'h1);
        check("eret_redirect_pc", redirect_pc, 32'h8000_0200);
        tick();
        check("eret_settle_flush", 32'(flush), 32'h0);
        tick();

        // Reset asserted during SETTLE.
        id_valid_1 = 1'b1; id_pc_1 = 32'h8000_0400;
        tick();
        clear_id();
        tick();
        cp0_cln_1 = 1'b1; cp0_intexp_1 = 1'b1; stall = 1'b1;
        tick();
        cp0_cln_1 = 1'b0; cp0_intexp_1 = 1'b0;
        tick();
        check("settle_pc_held", pc_1, 32'h8000_0400);
        reset = 1'b1; stall = 1'b0;
        tick();
        check("mid_rst_redirect_pc", redirect_pc, 32'h0);
        check("mid_rst_flush", 32'(flush), 32'h0);
        check("mid_rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("mid_rst_pc_1", pc_1, 32'h0);
        check("mid_rst_word_1", 32'(word_1), 32'h0);
        reset = 1'b0;
        cp0_cln_2 = 1'b1; EPC_o = 32'h8000_0300;
        tick();
        cp0_cln_2 = 1'b0;
        check("post_rst_idle_flush", 32'(flush), 32'h1);
        check("post_rst_redirect_pc", redirect_pc, 32'h8000_0300);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
